// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants: icodes, registers, status codes, controller modes
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] FNONE   = 4'h0;
  localparam logic [3:0] RRSP    = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [2:0] SBUB    = 3'd0;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;

  typedef enum logic [2:0] {
    RESET_MODE = 3'd0,
    RUN        = 3'd1,
    STEP       = 3'd2,
    PAUSE      = 3'd3,
    HALT       = 3'd4
  } mode_t;

  // A status that must stop the machine once it reaches write-back.
  function automatic logic is_exception(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline mode FSM, hazard stall/bubble control and hazard counters
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        pause_req,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic [2:0]  mode,
  output logic        F_stall,
  output logic        D_stall,
  output logic        W_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        halted,
  output logic [31:0] stall_count,
  output logic [31:0] bubble_count
);

  mode_t      state;
  logic [3:0] rst_cnt;

  logic load_use;
  logic mispredict;
  logic ret_pending;
  logic exc_m;
  logic exc_w;
  logic active;

  assign load_use    = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                       (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispredict  = (E_icode == IJXX) && !e_Cnd;
  assign ret_pending = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign exc_m       = is_exception(m_stat);
  assign exc_w       = is_exception(W_stat);
  assign active      = (state == RUN) || (state == STEP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RESET_MODE;
      rst_cnt <= 4'd0;
      halted  <= 1'b0;
    end else begin
      case (state)
        RESET_MODE: begin
          if (rst_cnt == 4'(RESET_CYCLES - 1)) begin
            state <= PAUSE;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        PAUSE: begin
          if (run_req) begin
            state <= RUN;
          end else if (step_req) begin
            state <= STEP;
          end
        end
        RUN: begin
          // A faulting write-back must stop the machine even if the host asked to pause.
          if (exc_w) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (pause_req) begin
            state <= PAUSE;
          end
        end
        STEP: begin
          if (exc_w) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= PAUSE;
          end
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state   <= RESET_MODE;
          rst_cnt <= 4'd0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign mode = state;

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    case (state)
      RUN, STEP: begin
        F_stall  = load_use || ret_pending;
        D_stall  = load_use;
        D_bubble = mispredict || (!load_use && ret_pending);
        E_bubble = mispredict || load_use;
        M_bubble = exc_m || exc_w;
        W_stall  = exc_w;
      end
      PAUSE, HALT: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
      default: begin
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
    endcase
  end

  // Only hazards seen while instructions actually flow are counted.
  sat_counter #(.WIDTH(32)) u_stall_count (
    .clock (clock),
    .reset (reset),
    .inc   (active && F_stall),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(32)) u_bubble_count (
    .clock (clock),
    .reset (reset),
    .inc   (active && (D_bubble || E_bubble)),
    .count (bubble_count)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: RESET_CYCLES, 4, number of cycles held in RESET_MODE after reset deasserts (range 1..15).
REQ-002 Port: clock  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high.
REQ-004 Port: run_req, step_req, pause_req  input  1 each  host mode commands, sampled every cycle.
REQ-005 Port: D_icode, E_icode, M_icode  input  4 each  icodes held in pipeline registers D, E, M.
REQ-006 Port: d_srcA, d_srcB, E_dstM  input  4 each  decode source registers and execute load destination (RNONE=4'hF).
REQ-007 Port: e_Cnd  input  1  branch condition computed in execute.
REQ-008 Port: m_stat, W_stat  input  3 each  memory-stage and write-back status.
REQ-009 Port: mode  output  3  current controller state; the fetch stage derives resetting from mode==RESET_MODE.
REQ-010 Port: F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble  output  1 each  pipeline register controls.
REQ-011 Port: halted  output  1  high while mode==HALT.
REQ-012 Port: stall_count, bubble_count  output  32 each  saturating hazard event counters.

Function
REQ-013 FSM states: RESET_MODE=0, RUN=1, STEP=2, PAUSE=3, HALT=4.
REQ-014 RESET_MODE: the FSM counts RESET_CYCLES cycles, then enters PAUSE.
REQ-015 PAUSE: run_req -> RUN; else step_req -> STEP; otherwise remain in PAUSE.
REQ-016 RUN: pause_req -> PAUSE at the next edge; run_req is ignored while in RUN.
REQ-017 STEP: lasts exactly one cycle, then -> PAUSE; requests arriving in STEP are ignored.
REQ-018 In RUN or STEP, a W_stat in {SHLT, SADR, SINS} -> HALT; this takes priority over pause_req.
REQ-019 HALT is left only by reset.
REQ-020 Stat encodings: SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4.
REQ-021 Icode encodings are standard Y86-64; this block uses IMRMOVQ=5, IJXX=7, IRET=9, IPOPQ=B.
REQ-022 load_use = (E_icode in {IMRMOVQ, IPOPQ}) & (E_dstM != RNONE) & (E_dstM == d_srcA | E_dstM == d_srcB).
REQ-023 mispredict = (E_icode == IJXX) & ~e_Cnd.
REQ-024 ret_pending = IRET in {D_icode, E_icode, M_icode}.
REQ-025 exc_m = m_stat in {SHLT, SADR, SINS}; exc_w = W_stat in {SHLT, SADR, SINS}.
REQ-026 Hazard outputs apply only in RUN and STEP, combinationally and in the same cycle: F_stall = load_use | ret_pending.
REQ-027 D_stall = load_use.
REQ-028 D_bubble = mispredict | (~load_use & ret_pending).
REQ-029 E_bubble = mispredict | load_use.
REQ-030 M_bubble = exc_m | exc_w.
REQ-031 W_stall = exc_w.
REQ-032 In PAUSE and HALT: all stalls = 1 and all bubbles = 0, freezing the pipeline.
REQ-033 In RESET_MODE: all bubbles = 1 and all stalls = 0.
REQ-034 stall_count increments by one per RUN/STEP cycle with F_stall=1.
REQ-035 bubble_count increments by one per RUN/STEP cycle with (D_bubble | E_bubble)=1.
REQ-036 Both counters saturate at 32'hFFFFFFFF and never wrap.
REQ-037 Simultaneous mispredict and load_use produce D_bubble=1, E_bubble=1, D_stall=1, F_stall=1; the branch fix wins via the bubble.

Reset
REQ-038 Reset overrides every other input at the clock edge, including mid-RUN and in HALT.
REQ-039 Values after reset: mode=RESET_MODE, reset-cycle counter=0, stall_count=0, bubble_count=0, halted=0.
REQ-040 Output values during reset follow REQ-033.

Structure
REQ-041 Stat codes, icodes, RNONE and mode encodings SHALL live in the shared Y86 constants package, alongside the existing fetch-stage constants.
REQ-042 The saturating counter SHALL be one sub-module, sat_counter (width parameter, inc, reset), instantiated twice.
REQ-043 The FSM and hazard logic remain in pipe_ctrl.

Verification
REQ-044 reset for 1 cycle, then idle -> mode=0 for 4 cycles with D/E/M_bubble=1, then mode=3 with all stalls=1.
REQ-045 In RUN: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0, stall_count +1 per cycle.
REQ-046 In RUN: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=E_bubble=1, F_stall=1 (ret_pending), bubble_count +1.
REQ-047 In RUN: W_stat=3 -> W_stall=M_bubble=1 that cycle; next cycle mode=4, halted=1; run_req then ignored until reset.
REQ-048 From PAUSE: step_req=1 for 1 cycle -> exactly one cycle with mode=2 and hazard-driven outputs, then mode=3.
REQ-049 stall_count preloaded to 32'hFFFFFFFE via force, load_use held 3 cycles -> count reads FFFFFFFF and holds.
